cic3_sample_fifo: RTL and testbench

Sample buffer placed directly downstream of the CIC3 decimator. It captures each 24-bit decimated sample on a one-cycle valid strobe and holds up to DEPTH samples in a first-word-fall-through FIFO. Readout uses a ready/valid handshake for the readout/serializer logic. A sticky overflow flag, a saturating dropped-sample counter and a 25-bit digital monitor mux are provided for debug through the same monitor-select scheme used by the CIC.

---
 rtl/cic3_sample_fifo.sv | 104 ++++++++++
 tb/tb_cic3_sample_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic3_sample_fifo.sv
// First-word-fall-through sample buffer behind the CIC3 decimator, with
// overflow/drop accounting and a 25-bit debug monitor mux.
module cic3_sample_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    input  logic                   clear_ovf,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count,
    input  logic [3:0]             digital_monitor_sel,
    output logic [24:0]            digital_monitor
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [15:0]      drop_cnt;

    logic full;
    logic pop;
    logic push;
    logic drop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign full     = (count == FULL_CNT);
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push     = in_valid & (~full | pop);
    assign drop     = in_valid & full & ~pop;
    assign rd_data  = mem[rd_ptr];

    // Storage is data-only and never reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear wins over the clear.
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= clear_ovf ? 16'd1 : sat_inc16(drop_cnt);
            end else if (clear_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

    always_comb begin
        digital_monitor = '0;
        case (digital_monitor_sel)
            4'd0: digital_monitor[WIDTH-1:0] = rd_data;
            4'd1: begin
                digital_monitor[24]     = rd_valid;
                digital_monitor[23]     = in_valid;
                digital_monitor[22]     = overflow;
                digital_monitor[CW-1:0] = count;
            end
            4'd2: digital_monitor[15:0] = drop_cnt;
            4'd3: begin
                digital_monitor[2*AW-1:AW] = wr_ptr;
                digital_monitor[AW-1:0]    = rd_ptr;
            end
            4'd4: digital_monitor[WIDTH-1:0] = in_data;
            default: digital_monitor = '0;
        endcase
    end

endmodule

// File: tb/tb_cic3_sample_fifo.sv
// Scoreboard bench for cic3_sample_fifo: a reference queue model predicts
// every readout, occupancy, overflow and drop count.
module tb_cic3_sample_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        clear_ovf;
    logic        overflow;
    logic [3:0]  count;
    logic [3:0]  digital_monitor_sel;
    logic [24:0] digital_monitor;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] m_q[$];
    int          m_count;
    logic        m_ovf;
    int          m_drop;

    cic3_sample_fifo #(.WIDTH(24), .DEPTH(8)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .rd_ready            (rd_ready),
        .clear_ovf           (clear_ovf),
        .overflow            (overflow),
        .count               (count),
        .digital_monitor_sel (digital_monitor_sel),
        .digital_monitor     (digital_monitor)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_drop  = 0;
    endtask

    // One clock: apply inputs, sample DUT before the edge, advance the model.
    task automatic drive(input logic iv, input logic [23:0] d, input logic rr,
                         input logic co, output logic mpop, output logic dut_vld,
                         output logic [23:0] seen);
        logic mpush;
        logic mdrop;
        in_valid  = iv;
        in_data   = d;
        rd_ready  = rr;
        clear_ovf = co;
        #3;
        dut_vld = rd_valid;
        seen    = rd_data;
        mpop  = (m_count > 0) && rr;
        mpush = iv && ((m_count < 8) || mpop);
        mdrop = iv && !mpush;
        if (mpush) m_q.push_back(d);
        if (mdrop) begin
            m_ovf  = 1'b1;
            m_drop = co ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
        end else if (co) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        m_count = m_count + int'(mpush) - int'(mpop);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        rd_ready  = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic test_reset_basic();
        logic mp, dv;
        logic [23:0] seen, exp;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 24'hDEAD01;
        rd_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        rd_ready = 1'b0;
        model_reset();
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d rd_valid=%b overflow=%b, need 0/0/0",
                     count, rd_valid, overflow);
        end
        for (int s = 1; s <= 3; s++) begin
            digital_monitor_sel = 4'(s);
            #1;
            vectors++;
            if (digital_monitor !== 25'd0) begin
                miscompares++;
                $display("FAIL reset_mon_sel%0d: got %h need 0", s, digital_monitor);
            end
        end
        digital_monitor_sel = 4'd0;
        for (int i = 1; i <= 3; i++) drive(1'b1, 24'(i), 1'b0, 1'b0, mp, dv, seen);
        vectors++;
        if (count !== 4'(m_count) || rd_valid !== 1'b1 || rd_data !== 24'h000001 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_fill: count=%0d vld=%b data=%h ovf=%b, need 3/1/000001/0",
                     count, rd_valid, rd_data, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 24'h0, 1'b1, 1'b0, mp, dv, seen);
            if (mp) begin
                exp = m_q.pop_front();
                vectors++;
                if (dv !== 1'b1 || seen !== exp) begin
                    miscompares++;
                    $display("FAIL basic_read%0d: vld=%b data=%h need 1/%h", i, dv, seen, exp);
                end
            end
        end
        drive(1'b0, 24'h0, 1'b1, 1'b0, mp, dv, seen);
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_empty: count=%0d vld=%b need 0/0", count, rd_valid);
        end
    endtask

    task automatic test_fill_overflow();
        logic mp, dv;
        logic [23:0] seen, exp;
        for (int i = 0; i < 10; i++) drive(1'b1, 24'h100000 + 24'(i), 1'b0, 1'b0, mp, dv, seen);
        digital_monitor_sel = 4'd2;
        #1;
        vectors++;
        if (count !== 4'd8 || overflow !== 1'b1 || digital_monitor !== 25'h0000002) begin
            miscompares++;
            $display("FAIL fill_overflow: count=%0d ovf=%b mon2=%h need 8/1/0000002",
                     count, overflow, digital_monitor);
        end
        digital_monitor_sel = 4'd0;
        for (int k = 0; k < 20 && m_count > 0; k++) begin
            drive(1'b0, 24'h0, 1'b1, 1'b0, mp, dv, seen);
            if (mp) begin
                exp = m_q.pop_front();
                vectors++;
                if (dv !== 1'b1 || seen !== exp) begin
                    miscompares++;
                    $display("FAIL fill_drain: vld=%b data=%h need 1/%h", dv, seen, exp);
                end
            end
        end
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_drain_empty: count=%0d vld=%b need 0/0", count, rd_valid);
        end
    endtask

    task automatic test_full_simultaneous();
        logic mp, dv;
        logic [23:0] seen, exp, last;
        last = 24'h0;
        for (int i = 0; i < 8; i++) drive(1'b1, 24'h200000 + 24'(i), 1'b0, 1'b0, mp, dv, seen);
        drive(1'b1, 24'hABCDEF, 1'b1, 1'b0, mp, dv, seen);
        if (mp) begin
            exp = m_q.pop_front();
            vectors++;
            if (seen !== exp) begin
                miscompares++;
                $display("FAIL simul_pop: data=%h need %h", seen, exp);
            end
        end
        vectors++;
        if (count !== 4'd8 || overflow !== m_ovf) begin
            miscompares++;
            $display("FAIL simul_state: count=%0d ovf=%b need 8/%b", count, overflow, m_ovf);
        end
        for (int k = 0; k < 20 && m_count > 0; k++) begin
            drive(1'b0, 24'h0, 1'b1, 1'b0, mp, dv, seen);
            if (mp) begin
                exp = m_q.pop_front();
                last = seen;
                vectors++;
                if (dv !== 1'b1 || seen !== exp) begin
                    miscompares++;
                    $display("FAIL simul_drain: vld=%b data=%h need 1/%h", dv, seen, exp);
                end
            end
        end
        vectors++;
        if (last !== 24'hABCDEF || count !== 4'd0) begin
            miscompares++;
            $display("FAIL simul_last: last=%h count=%0d need ABCDEF/0", last, count);
        end
    endtask

    task automatic test_clear_vs_drop();
        logic mp, dv;
        logic [23:0] seen, exp;
        for (int i = 0; i < 8; i++) drive(1'b1, 24'h300000 + 24'(i), 1'b0, 1'b0, mp, dv, seen);
        digital_monitor_sel = 4'd2;
        drive(1'b1, 24'h3FFFFF, 1'b0, 1'b1, mp, dv, seen);
        vectors++;
        if (overflow !== 1'b1 || digital_monitor !== 25'd1 || m_drop != 1) begin
            miscompares++;
            $display("FAIL clear_drop: ovf=%b drop=%h need 1/0000001", overflow, digital_monitor);
        end
        drive(1'b0, 24'h0, 1'b0, 1'b1, mp, dv, seen);
        vectors++;
        if (overflow !== 1'b0 || digital_monitor !== 25'd0 || count !== 4'd8) begin
            miscompares++;
            $display("FAIL clear_only: ovf=%b drop=%h count=%0d need 0/0/8",
                     overflow, digital_monitor, count);
        end
        digital_monitor_sel = 4'd0;
        for (int k = 0; k < 20 && m_count > 0; k++) begin
            drive(1'b0, 24'h0, 1'b1, 1'b0, mp, dv, seen);
            if (mp) begin
                exp = m_q.pop_front();
                vectors++;
                if (seen !== exp) begin
                    miscompares++;
                    $display("FAIL clear_drain: data=%h need %h", seen, exp);
                end
            end
        end
    endtask

    task automatic test_wrap_around();
        logic mp, dv;
        logic [23:0] seen, exp;
        logic [2:0] prev_wp;
        int wraps = 0;
        int n = 0;
        digital_monitor_sel = 4'd3;
        for (int c = 0; c < 42; c++) begin
            #1;
            prev_wp = digital_monitor[5:3];
            if (c % 2 == 0 && n < 20) begin
                drive(1'b1, 24'(n), 1'b1, 1'b0, mp, dv, seen);
                n++;
            end else begin
                drive(1'b0, 24'h0, 1'b1, 1'b0, mp, dv, seen);
            end
            #1;
            if (prev_wp == 3'd7 && digital_monitor[5:3] == 3'd0) wraps++;
            if (mp) begin
                exp = m_q.pop_front();
                vectors++;
                if (seen !== exp) begin
                    miscompares++;
                    $display("FAIL wrap_data: data=%h need %h", seen, exp);
                end
            end
            vectors++;
            if (count !== 4'(m_count) || count > 4'd1) begin
                miscompares++;
                $display("FAIL wrap_count: count=%0d need %0d (max 1)", count, m_count);
            end
        end
        vectors++;
        if (wraps < 2 || n != 20) begin
            miscompares++;
            $display("FAIL wrap_ptr: wr_ptr wraps=%0d pushes=%0d need >=2/20", wraps, n);
        end
        digital_monitor_sel = 4'd0;
    endtask

    task automatic test_reset_mid_stream();
        logic mp, dv;
        logic [23:0] seen, exp;
        for (int i = 0; i < 5; i++) drive(1'b1, 24'h400000 + 24'(i), 1'b0, 1'b0, mp, dv, seen);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_data  = 24'h4BAD00;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        model_reset();
        vectors++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: count=%0d vld=%b ovf=%b need 0/0/0",
                     count, rd_valid, overflow);
        end
        drive(1'b1, 24'h055555, 1'b0, 1'b0, mp, dv, seen);
        drive(1'b0, 24'h0, 1'b1, 1'b0, mp, dv, seen);
        if (mp) exp = m_q.pop_front();
        else exp = 24'hXXXXXX;
        vectors++;
        if (dv !== 1'b1 || seen !== 24'h055555 || exp !== 24'h055555) begin
            miscompares++;
            $display("FAIL midreset_first: vld=%b data=%h need 1/055555", dv, seen);
        end
        vectors++;
        if (count !== 4'd0) begin
            miscompares++;
            $display("FAIL midreset_empty: count=%0d need 0", count);
        end
    endtask

    initial begin
        reset_n             = 1'b0;
        in_data             = '0;
        in_valid            = 1'b0;
        rd_ready            = 1'b0;
        clear_ovf           = 1'b0;
        digital_monitor_sel = 4'd0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset_basic();
        test_fill_overflow();
        test_full_simultaneous();
        test_clear_vs_drop();
        test_wrap_around();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
